// File: rtl/sll8_seq_if.sv
// sll8_seq_if: request/result bundle for the sequential 8-bit shift-left unit.
//   start      request strobe (sampled by the unit only while idle)
//   A, B       operand and unsigned shift amount, captured on accepted start
//   C, cout    result and last bit shifted out of C[7]
//   busy, done unit-active flag and one-cycle completion pulse
// master: requester side. slave: the shift unit.
interface sll8_seq_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] C;
  logic       cout;
  logic       busy;
  logic       done;

  modport master (
    output start, A, B,
    input  C, cout, busy, done
  );

  modport slave (
    input  start, A, B,
    output C, cout, busy, done
  );
endinterface

// File: rtl/sll8_seq.sv
// sll8_seq: iterative 8-bit logical shift-left, one position per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sll8_seq_if.slave: start/A/B in; C/cout/busy/done out
// An accepted start loads A into C and either finishes immediately
// (B==0 keeps A, B>=9 clears C) or shifts B times before a one-cycle done.
module sll8_seq (
  input  logic        clk,
  input  logic        rst_n,
  sll8_seq_if.slave   bus
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [DATA_W-1:0]   c_q, c_nxt;
  logic                cout_q, cout_nxt;
  logic [3:0]          cnt_q, cnt_nxt;

  // Amounts beyond the operand width shift everything out; cout stays 0
  // because the unit does not iterate for them.
  function automatic logic out_of_range(input logic [7:0] amt);
    return (amt > 8'd8);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      c_q     <= c_nxt;
      cout_q  <= cout_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    c_nxt     = c_q;
    cout_nxt  = cout_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          c_nxt    = bus.A;
          cout_nxt = 1'b0;
          if (bus.B == 8'd0) begin
            state_nxt = DONE;
          end else if (out_of_range(bus.B)) begin
            c_nxt     = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = bus.B[3:0];
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        cout_nxt = c_q[DATA_W-1];
        c_nxt    = {c_q[DATA_W-2:0], 1'b0};
        cnt_nxt  = cnt_q - 4'd1;
        // Counter value 1 marks the final shift; <=1 also guards a zero count.
        if (cnt_q <= 4'd1) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.C    = c_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_sll8_seq.sv
module tb_sll8_seq;

  logic clk;
  logic rst_n;

  sll8_seq_if bus ();

  sll8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       co;
    int         lat;
  } vec_t;

  vec_t tbl [7];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: wide shift then truncate; cout is the bit that
  // leaves position 7 on the final shift.
  function automatic logic [7:0] ref_c(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    if (b > 8'd8) return 8'h00;
    w = {8'h00, a} << b;
    return w[7:0];
  endfunction

  function automatic logic ref_co(input logic [7:0] a, input logic [7:0] b);
    if (b >= 8'd1 && b <= 8'd8) return a[8 - int'(b)];
    return 1'b0;
  endfunction

  function automatic int ref_lat(input logic [7:0] b);
    if (b == 8'd0 || b > 8'd8) return 1;
    return int'(b) + 1;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ec, input logic eco, input int lat,
                        input string tag);
    int  k;
    bit  seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 8'($urandom);
    bus.B     = 8'($urandom);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
      else chk({tag, " busy"}, int'(bus.busy), 1);
    end
    chk({tag, " done cycle"}, k, lat);
    chk({tag, " C"}, int'(bus.C), int'(ec));
    chk({tag, " cout"}, int'(bus.cout), int'(eco));
    @(negedge clk);
    chk({tag, " done width"}, int'(bus.done), 0);
    chk({tag, " idle busy"}, int'(bus.busy), 0);
    chk({tag, " C held"}, int'(bus.C), int'(ec));
  endtask

  initial begin
    logic [7:0] alist [5];
    int         dn;
    int         first_done;

    n_cmp  = 0;
    n_fail = 0;
    alist[0] = 8'h00; alist[1] = 8'h01; alist[2] = 8'h80;
    alist[3] = 8'hA5; alist[4] = 8'hFF;

    tbl[0] = '{a: 8'hB5, b: 8'd3,   c: 8'hA8, co: 1'b1, lat: 4};
    tbl[1] = '{a: 8'h81, b: 8'd8,   c: 8'h00, co: 1'b1, lat: 9};
    tbl[2] = '{a: 8'h80, b: 8'd1,   c: 8'h00, co: 1'b1, lat: 2};
    tbl[3] = '{a: 8'h5A, b: 8'd0,   c: 8'h5A, co: 1'b0, lat: 1};
    tbl[4] = '{a: 8'hFF, b: 8'h20,  c: 8'h00, co: 1'b0, lat: 1};
    tbl[5] = '{a: 8'hFF, b: 8'd9,   c: 8'h00, co: 1'b0, lat: 1};
    tbl[6] = '{a: 8'h03, b: 8'd2,   c: 8'h0C, co: 1'b0, lat: 3};

    bus.start = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset C", int'(bus.C), 0);
    chk("reset cout", int'(bus.cout), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].co, tbl[i].lat,
             $sformatf("vec%0d", i));

    // start held high while busy must not re-capture A/B
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'h01;
    bus.B     = 8'd5;
    @(posedge clk);
    #1;
    bus.A = 8'hFF;
    bus.B = 8'd1;
    dn         = 0;
    first_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) bus.start = 1'b0;
      if (bus.done) begin
        dn++;
        if (first_done == 0) begin
          first_done = k;
          chk("busyprot C", int'(bus.C), 8'h20);
          chk("busyprot cout", int'(bus.cout), 0);
        end
      end
    end
    chk("busyprot done count", dn, 1);
    chk("busyprot done cycle", first_done, 6);

    // Async reset in the middle of a shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'hF0;
    bus.B     = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst C", int'(bus.C), 0);
    chk("midrst cout", int'(bus.cout), 0);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("midrst no done", dn, 0);
    run_op(8'h03, 8'd2, 8'h0C, 1'b0, 3, "postrst");

    // Sweep against the reference model
    for (int ai = 0; ai < 5; ai++)
      for (int b = 0; b <= 10; b++)
        run_op(alist[ai], 8'(b), ref_c(alist[ai], 8'(b)),
               ref_co(alist[ai], 8'(b)), ref_lat(8'(b)),
               $sformatf("sweep a=%0h b=%0d", alist[ai], b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sll8_seq.md
# sll8_seq

Sequential 8-bit logical shift-left unit: the left-shift counterpart of the combinational 8-bit logical right shifter in the ALU datapath. It accepts an operand and an 8-bit shift amount on a start strobe and shifts left one position per clock. It returns the result, the last bit shifted out of the MSB, and a one-cycle done pulse. It serves the sequential ALU path, where an area-cheap iterative shifter replaces a barrel shifter.

## Interface
- N, 8, operand/result width; the block is verified at N=8 only.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe, sampled only in IDLE.
- A  input  8  operand, captured when start is accepted.
- B  input  8  unsigned shift amount, captured when start is accepted.
- C  output  8  result register.
- cout  output  1  last bit shifted out of C[7]; 0 if no bit was shifted out.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; C and cout are valid in that cycle.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: shifts one position per cycle while the remaining count is nonzero.
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- Start acceptance: start=1 in IDLE is accepted at that clock edge. A is loaded into C, cout is cleared, and B is decoded:
  - B==0: go to DONE. C=A, cout=0.
  - 1<=B<=8: load the 4-bit counter with B[3:0] and go to SHIFT.
  - B>=9 (any of B[7:4] set, or B[3:0]>8): go to DONE with C=0x00 and cout=0.
- SHIFT, each cycle: cout<=C[7]; C<={C[6:0],1'b0}; counter decrements. When the counter reaches 1, the final shift occurs and the next state is DONE.
- Result: C = (A << B) truncated to 8 bits. cout = A[8-B] for 1<=B<=8, else 0.
- start while busy: ignored; A and B are not re-captured and no error is flagged.
- C changes during SHIFT and is intermediate there. It is valid in DONE and holds its value through IDLE until the next accepted start.
- A and B may change freely after the accepting edge.

## Timing
- Reset (async assert, any state): state=IDLE, C=0x00, cout=0, busy=0, done=0, counter=0.
- Reset deassertion is synchronised externally. The first start is honoured on the first clock edge with rst_n=1.
- Let edge T accept start:
  - B==0 or B>=9: done=1 during cycle T+1 (the cycle after T). busy=1 in T+1 only.
  - 1<=B<=8: shifts occur at edges T+1..T+B, and done=1 during cycle T+B+1. busy=1 for cycles T+1..T+B+1.
- Throughput: start may be reasserted in the cycle after done (IDLE). Back-to-back operations therefore have one idle cycle between done and the next busy.
- Reset mid-SHIFT: the operation is aborted with no done pulse, and all outputs return to reset values immediately (asynchronously).
- start asserted in the DONE cycle: ignored. It must be held or reasserted in IDLE.
- done is never asserted for more than one consecutive cycle.

## Test plan
- Basic shift: A=0xB5, B=3 at edge T. C=0xA8 and cout=1 with done during T+4; busy during T+1..T+4; C stays 0xA8 afterwards in IDLE.
- Full shift: A=0x81, B=8. C=0x00, cout=1, done during T+9. Then A=0x80, B=1 → C=0x00, cout=1, done during T+2.
- Degenerate amounts:
  - A=0x5A, B=0 → C=0x5A, cout=0, done during T+1.
  - A=0xFF, B=0x20 → C=0x00, cout=0, done during T+1.
  - A=0xFF, B=9 → C=0x00, cout=0, done during T+1.
- Busy protection: A=0x01, B=5, then start=1 with A=0xFF, B=1 during busy cycles. Result is C=0x20, cout=0 with exactly one done pulse during T+6.
- Reset mid-operation: A=0xF0, B=7, rst_n=0 at cycle T+3 for 1 cycle. C=0x00, cout=0, busy=0 immediately, and no done pulse. Then A=0x03, B=2 → C=0x0C, cout=0.
- Sweep: all A in {0x00, 0x01, 0x80, 0xA5, 0xFF} × B in 0..10. C, cout and done cycle must match the reference model (A<<B)[7:0], with cout = A[8-B] for 1<=B<=8, else 0.
